// File: rtl/fma_line_unpacker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fma_line_unpacker_if
// Brief   : Line-in / beat-out handshake bundle for fma_line_unpacker.
// Rev     : 1.0
// ============================================================================
interface fma_line_unpacker_if #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WIDTH = 96
);
    logic [LINE_WIDTH-1:0]           line_in;
    logic                            line_valid_in;
    logic                            line_ready_out;
    logic [WORD_WIDTH*FMA_COUNT-1:0] words_out;
    logic                            words_valid_out;
    logic                            words_ready_in;
    logic                            last_out;

    modport slave (
        input  line_in, line_valid_in, words_ready_in,
        output line_ready_out, words_out, words_valid_out, last_out
    );

    modport master (
        output line_in, line_valid_in, words_ready_in,
        input  line_ready_out, words_out, words_valid_out, last_out
    );
endinterface
`default_nettype wire

// File: rtl/fma_line_unpacker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fma_line_unpacker
// Brief   : Serialises LINE_WIDTH memory lines into FMA_COUNT-word beats,
//           MSB slice first, through a 2-entry line FIFO.
//           Optional macro UNPACK_STATS_EN adds the lines_done_out counter.
// Rev     : 1.0
// ============================================================================
module fma_line_unpacker #(
    parameter int FMA_COUNT  = 2,
    parameter int WORD_WIDTH = 16,
    parameter int LINE_WIDTH = 96
) (
    input  wire logic              clk_in,
    input  wire logic              rst_in,
    fma_line_unpacker_if.slave     bus,
`ifdef UNPACK_STATS_EN
    output logic [15:0]            lines_done_out,
`endif
    output logic                   idle_out
);
    localparam int BEAT_WIDTH = WORD_WIDTH * FMA_COUNT;
    localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    generate
        if ((LINE_WIDTH % BEAT_WIDTH) != 0 || BEATS == 0) begin : g_bad_width
            $fatal(1, "LINE_WIDTH must be a multiple of WORD_WIDTH*FMA_COUNT");
        end
    endgenerate

    logic [LINE_WIDTH-1:0] mem_q [2];
    logic [LINE_WIDTH-1:0] mem_d [2];
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;

    logic                  push;
    logic                  pop;
    logic                  retire;
    logic                  words_valid;
    logic                  last_beat;
    logic [BEAT_WIDTH-1:0] beat_slices [BEATS];
    logic [BEAT_WIDTH-1:0] head_beat;

    // Beat k of the head line is the k-th slice counted down from the MSB.
    genvar k;
    generate
        for (k = 0; k < BEATS; k++) begin : g_slice
            assign beat_slices[k] = mem_q[rd_ptr_q][LINE_WIDTH-1-k*BEAT_WIDTH -: BEAT_WIDTH];
        end
        if (BEATS == 1) begin : g_one_beat
            assign head_beat = beat_slices[0];
        end else begin : g_multi_beat
            assign head_beat = beat_slices[beat_q];
        end
    endgenerate

    always_comb begin
        words_valid = (count_q != 2'd0);
        last_beat   = (beat_q == LAST_BEAT);
        push        = bus.line_valid_in && (count_q != 2'd2);
        retire      = words_valid && bus.words_ready_in;
        pop         = retire && last_beat;

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.line_in;
            wr_ptr_d        = ~wr_ptr_q;
        end

        if (retire) begin
            if (last_beat) begin
                beat_d   = '0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                beat_d   = beat_q + BEAT_CNT_W'(1);
            end
        end

        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            beat_q   <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
        end
    end

    assign bus.line_ready_out  = (count_q != 2'd2);
    assign bus.words_valid_out = words_valid;
    assign bus.words_out       = words_valid ? head_beat : '0;
    assign bus.last_out        = words_valid && last_beat;
    assign idle_out            = (count_q == 2'd0);

`ifdef UNPACK_STATS_EN
    logic [15:0] lines_done_q, lines_done_d;

    always_comb begin
        lines_done_d = lines_done_q;
        if (pop) begin
            lines_done_d = lines_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            lines_done_q <= 16'd0;
        end else begin
            lines_done_q <= lines_done_d;
        end
    end

    assign lines_done_out = lines_done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fma_line_unpacker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fma_line_unpacker
// Brief   : Scoreboard bench for fma_line_unpacker (default and FMA_COUNT=1).
// Rev     : 1.0
// ============================================================================
module tb_fma_line_unpacker;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    fma_line_unpacker_if #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96)) bus_a ();
    fma_line_unpacker_if #(.FMA_COUNT(1), .WORD_WIDTH(16), .LINE_WIDTH(48)) bus_b ();
    logic idle_a;
    logic idle_b;
`ifdef UNPACK_STATS_EN
    fma_line_unpacker_if #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(32)) bus_c ();
    logic        idle_c;
    logic [15:0] done_a, done_b, done_c;
`endif

    fma_line_unpacker #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96)) dut_a (
        .clk_in(clk), .rst_in(rst), .bus(bus_a),
`ifdef UNPACK_STATS_EN
        .lines_done_out(done_a),
`endif
        .idle_out(idle_a)
    );

    fma_line_unpacker #(.FMA_COUNT(1), .WORD_WIDTH(16), .LINE_WIDTH(48)) dut_b (
        .clk_in(clk), .rst_in(rst), .bus(bus_b),
`ifdef UNPACK_STATS_EN
        .lines_done_out(done_b),
`endif
        .idle_out(idle_b)
    );

`ifdef UNPACK_STATS_EN
    fma_line_unpacker #(.FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(32)) dut_c (
        .clk_in(clk), .rst_in(rst), .bus(bus_c),
        .lines_done_out(done_c),
        .idle_out(idle_c)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected beats as {last, words}.
    logic [32:0] exp_a [$];
    logic [16:0] exp_b [$];

    always @(negedge clk) begin
        if (!rst && bus_a.words_valid_out && bus_a.words_ready_in) begin
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_err++;
                $display("FAIL beat_a_unexpected got %h expected no beat", {bus_a.last_out, bus_a.words_out});
            end else begin
                logic [32:0] e;
                e = exp_a.pop_front();
                if ({bus_a.last_out, bus_a.words_out} !== e) begin
                    n_err++;
                    $display("FAIL beat_a got %h expected %h", {bus_a.last_out, bus_a.words_out}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus_b.words_valid_out && bus_b.words_ready_in) begin
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_err++;
                $display("FAIL beat_b_unexpected got %h expected no beat", {bus_b.last_out, bus_b.words_out});
            end else begin
                logic [16:0] e;
                e = exp_b.pop_front();
                if ({bus_b.last_out, bus_b.words_out} !== e) begin
                    n_err++;
                    $display("FAIL beat_b got %h expected %h", {bus_b.last_out, bus_b.words_out}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp_a(input logic [95:0] ln);
        for (int k = 0; k < 3; k++) begin
            exp_a.push_back({(k == 2), ln[95-k*32 -: 32]});
        end
    endtask

    task automatic drain_a();
        bus_a.words_ready_in = 1'b1;
        for (int i = 0; i < 40 && (exp_a.size() != 0 || bus_a.words_valid_out); i++) tick();
        n_cmp++;
        if (exp_a.size() != 0 || idle_a !== 1'b1) begin
            n_err++;
            $display("FAIL drain_a pending=%0d idle=%b expected pending=0 idle=1", exp_a.size(), idle_a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.line_in = '0; bus_a.line_valid_in = 1'b0; bus_a.words_ready_in = 1'b0;
        bus_b.line_in = '0; bus_b.line_valid_in = 1'b0; bus_b.words_ready_in = 1'b0;
`ifdef UNPACK_STATS_EN
        bus_c.line_in = '0; bus_c.line_valid_in = 1'b0; bus_c.words_ready_in = 1'b0;
`endif
        repeat (3) tick();
        n_cmp++; if (bus_a.line_ready_out !== 1'b1) begin n_err++; $display("FAIL reset_line_ready got %b expected 1", bus_a.line_ready_out); end
        n_cmp++; if (bus_a.words_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_words_valid got %b expected 0", bus_a.words_valid_out); end
        n_cmp++; if (bus_a.words_out !== 32'h0) begin n_err++; $display("FAIL reset_words got %h expected 0", bus_a.words_out); end
        n_cmp++; if (bus_a.last_out !== 1'b0) begin n_err++; $display("FAIL reset_last got %b expected 0", bus_a.last_out); end
        n_cmp++; if (idle_a !== 1'b1 || idle_b !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b%b expected 11", idle_a, idle_b); end
`ifdef UNPACK_STATS_EN
        n_cmp++; if (done_a !== 16'h0) begin n_err++; $display("FAIL reset_lines_done got %h expected 0", done_a); end
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_line();
        bus_a.words_ready_in = 1'b1;
        bus_a.line_in        = 96'h0001_0002_0003_0004_0005_0006;
        bus_a.line_valid_in  = 1'b1;
        exp_a.push_back(33'h0_0001_0002);
        exp_a.push_back(33'h0_0003_0004);
        exp_a.push_back(33'h1_0005_0006);
        tick();
        bus_a.line_valid_in = 1'b0;
        n_cmp++; if (bus_a.words_valid_out !== 1'b1 || bus_a.words_out !== 32'h0001_0002) begin
            n_err++; $display("FAIL single_first_beat got v=%b w=%h expected v=1 w=00010002", bus_a.words_valid_out, bus_a.words_out); end
        n_cmp++; if (bus_a.last_out !== 1'b0) begin n_err++; $display("FAIL single_last_beat0 got %b expected 0", bus_a.last_out); end
        tick();
        n_cmp++; if (bus_a.last_out !== 1'b0) begin n_err++; $display("FAIL single_last_beat1 got %b expected 0", bus_a.last_out); end
        tick();
        n_cmp++; if (bus_a.last_out !== 1'b1) begin n_err++; $display("FAIL single_last_beat2 got %b expected 1", bus_a.last_out); end
        tick();
        n_cmp++; if (idle_a !== 1'b1 || exp_a.size() != 0) begin
            n_err++; $display("FAIL single_idle_after got idle=%b pending=%0d expected idle=1 pending=0", idle_a, exp_a.size()); end
    endtask

    task automatic test_backpressure();
        logic [95:0] la, lb, lc;
        la = 96'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5;
        lb = 96'hB0B0_B1B1_B2B2_B3B3_B4B4_B5B5;
        lc = 96'hC0C0_C1C1_C2C2_C3C3_C4C4_C5C5;
        bus_a.words_ready_in = 1'b0;
        bus_a.line_in = la; bus_a.line_valid_in = 1'b1; push_exp_a(la);
        tick();
        n_cmp++; if (bus_a.line_ready_out !== 1'b1) begin n_err++; $display("FAIL bp_ready_one got %b expected 1", bus_a.line_ready_out); end
        bus_a.line_in = lb; push_exp_a(lb);
        tick();
        n_cmp++; if (bus_a.line_ready_out !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b expected 0", bus_a.line_ready_out); end
        bus_a.line_in = lc;
        tick(); tick();
        n_cmp++; if (bus_a.words_valid_out !== 1'b1 || bus_a.words_out !== la[95:64] || bus_a.last_out !== 1'b0) begin
            n_err++; $display("FAIL bp_frozen got v=%b w=%h l=%b expected v=1 w=%h l=0", bus_a.words_valid_out, bus_a.words_out, bus_a.last_out, la[95:64]); end
        n_cmp++; if (bus_a.line_ready_out !== 1'b0) begin n_err++; $display("FAIL bp_c_held got %b expected 0", bus_a.line_ready_out); end
        bus_a.words_ready_in = 1'b1;
        tick(); tick();
        n_cmp++; if (bus_a.line_ready_out !== 1'b0 || bus_a.last_out !== 1'b1) begin
            n_err++; $display("FAIL bp_final_a got ready=%b last=%b expected ready=0 last=1", bus_a.line_ready_out, bus_a.last_out); end
        push_exp_a(lc);
        tick();
        n_cmp++; if (bus_a.line_ready_out !== 1'b1 || bus_a.words_out !== lb[95:64]) begin
            n_err++; $display("FAIL bp_b_no_bubble got ready=%b w=%h expected ready=1 w=%h", bus_a.line_ready_out, bus_a.words_out, lb[95:64]); end
        tick();
        bus_a.line_valid_in = 1'b0;
        n_cmp++; if (bus_a.line_ready_out !== 1'b0) begin n_err++; $display("FAIL bp_c_accepted got ready=%b expected 0", bus_a.line_ready_out); end
        drain_a();
    endtask

    task automatic test_simul_push_pop();
        logic [95:0] lp, lq;
        lp = 96'h7070_7171_7272_7373_7474_7575;
        lq = 96'h1111_2222_3333_4444_5555_6666;
        bus_a.words_ready_in = 1'b1;
        bus_a.line_in = lp; bus_a.line_valid_in = 1'b1; push_exp_a(lp);
        tick();
        bus_a.line_valid_in = 1'b0;
        tick(); tick();
        bus_a.line_in = lq; bus_a.line_valid_in = 1'b1; push_exp_a(lq);
        tick();
        bus_a.line_valid_in = 1'b0;
        n_cmp++; if (idle_a !== 1'b0 || bus_a.line_ready_out !== 1'b1 || bus_a.words_out !== 32'h1111_2222) begin
            n_err++; $display("FAIL simul_head got idle=%b ready=%b w=%h expected idle=0 ready=1 w=11112222", idle_a, bus_a.line_ready_out, bus_a.words_out); end
        tick();
        n_cmp++; if (bus_a.words_out !== 32'h3333_4444) begin n_err++; $display("FAIL simul_beat1 got %h expected 33334444", bus_a.words_out); end
        tick();
        n_cmp++; if (bus_a.words_out !== 32'h5555_6666 || bus_a.last_out !== 1'b1) begin
            n_err++; $display("FAIL simul_beat2 got w=%h l=%b expected w=55556666 l=1", bus_a.words_out, bus_a.last_out); end
        drain_a();
    endtask

    task automatic test_reset_mid_line();
        logic [95:0] lr, ls;
        lr = 96'hD0D0_D1D1_D2D2_D3D3_D4D4_D5D5;
        ls = 96'hE0E0_E1E1_E2E2_E3E3_E4E4_E5E5;
        bus_a.words_ready_in = 1'b1;
        bus_a.line_in = lr; bus_a.line_valid_in = 1'b1; push_exp_a(lr);
        tick();
        bus_a.line_valid_in = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_a.words_valid_out !== 1'b0 || bus_a.words_out !== 32'h0 || bus_a.last_out !== 1'b0) begin
            n_err++; $display("FAIL midrst_outputs got v=%b w=%h l=%b expected v=0 w=0 l=0", bus_a.words_valid_out, bus_a.words_out, bus_a.last_out); end
        n_cmp++; if (bus_a.line_ready_out !== 1'b1 || idle_a !== 1'b1) begin
            n_err++; $display("FAIL midrst_ready got ready=%b idle=%b expected 1 1", bus_a.line_ready_out, idle_a); end
        n_cmp++; if (exp_a.size() != 1) begin n_err++; $display("FAIL midrst_beats_seen got pending=%0d expected 1", exp_a.size()); end
        exp_a.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus_a.line_in = ls; bus_a.line_valid_in = 1'b1; push_exp_a(ls);
        tick();
        bus_a.line_valid_in = 1'b0;
        n_cmp++; if (bus_a.words_out !== ls[95:64] || bus_a.last_out !== 1'b0) begin
            n_err++; $display("FAIL midrst_restart got w=%h l=%b expected w=%h l=0", bus_a.words_out, bus_a.last_out, ls[95:64]); end
        drain_a();
    endtask

    task automatic test_back_to_back();
        logic [95:0] ln;
        logic [31:0] hw;
        logic        hl;
        bit          acc, hold;
        int          sent = 0;
        ln = {$urandom, $urandom, $urandom};
        bus_a.line_in = ln; bus_a.line_valid_in = 1'b1;
        for (int c = 0; c < 400 && sent < 6; c++) begin
            bus_a.words_ready_in = 1'($urandom_range(0, 1));
            acc  = bus_a.line_valid_in && bus_a.line_ready_out;
            if (acc) push_exp_a(ln);
            hold = bus_a.words_valid_out && !bus_a.words_ready_in;
            hw   = bus_a.words_out;
            hl   = bus_a.last_out;
            tick();
            if (hold) begin
                n_cmp++;
                if (bus_a.words_out !== hw || bus_a.last_out !== hl) begin
                    n_err++; $display("FAIL b2b_stable got w=%h l=%b expected w=%h l=%b", bus_a.words_out, bus_a.last_out, hw, hl); end
            end
            if (acc) begin
                sent++;
                if (sent < 6) begin
                    ln = {$urandom, $urandom, $urandom};
                    bus_a.line_in = ln;
                end else begin
                    bus_a.line_valid_in = 1'b0;
                end
            end
        end
        n_cmp++; if (sent != 6) begin n_err++; $display("FAIL b2b_lines_sent got %0d expected 6", sent); end
        bus_a.line_valid_in = 1'b0;
        drain_a();
    endtask

    task automatic test_param_sweep();
        bus_b.words_ready_in = 1'b1;
        bus_b.line_in = 48'hAAAA_BBBB_CCCC; bus_b.line_valid_in = 1'b1;
        exp_b.push_back(17'h0_AAAA);
        exp_b.push_back(17'h0_BBBB);
        exp_b.push_back(17'h1_CCCC);
        tick();
        bus_b.line_valid_in = 1'b0;
        n_cmp++; if (bus_b.words_valid_out !== 1'b1 || bus_b.words_out !== 16'hAAAA) begin
            n_err++; $display("FAIL sweep_first got v=%b w=%h expected v=1 w=aaaa", bus_b.words_valid_out, bus_b.words_out); end
        for (int i = 0; i < 20 && (exp_b.size() != 0 || bus_b.words_valid_out); i++) tick();
        n_cmp++; if (exp_b.size() != 0 || idle_b !== 1'b1) begin
            n_err++; $display("FAIL sweep_drain got pending=%0d idle=%b expected 0 1", exp_b.size(), idle_b); end
    endtask

`ifdef UNPACK_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (done_a !== 16'h0 || done_c !== 16'h0) begin
            n_err++; $display("FAIL stats_reset got a=%h c=%h expected 0 0", done_a, done_c); end
        tick();
        n_cmp++; if (done_c !== 16'h0) begin n_err++; $display("FAIL stats_in_reset got %h expected 0", done_c); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus_c.words_ready_in = 1'b1;
        bus_c.line_valid_in  = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            bus_c.line_in = 32'(i);
            tick();
            if (i == 9) begin
                n_cmp++; if (done_c !== 16'd9) begin n_err++; $display("FAIL stats_partial got %0d expected 9", done_c); end
            end
        end
        bus_c.line_valid_in = 1'b0;
        tick();
        n_cmp++; if (done_c !== 16'h0001) begin n_err++; $display("FAIL stats_wrap got %h expected 0001", done_c); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_line();
        test_backpressure();
        test_simul_push_pop();
        test_reset_mid_line();
        test_back_to_back();
        test_param_sweep();
`ifdef UNPACK_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fma_line_unpacker.md
Name: fma_line_unpacker

Overview:
- Inverse of fma_write_buffer: takes full LINE_WIDTH lines from memory and serialises them into per-FMA word beats, one WORD_WIDTH word per FMA lane per beat.
- Sits between the memory read path and the FMA lanes, or any per-lane consumer.
- Uses a 2-entry line FIFO and a beat counter, with valid/ready on both sides.

Parameters:
- FMA_COUNT, 2, number of FMA lanes (words per beat).
- WORD_WIDTH, 16, bits per word.
- LINE_WIDTH, 96, bits per line.
- Derived localparam BEATS = LINE_WIDTH/(WORD_WIDTH*FMA_COUNT), default 3.
- LINE_WIDTH must be an exact multiple of WORD_WIDTH*FMA_COUNT; elaboration fatal otherwise.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, asynchronous, active-high.
- line_in  in  LINE_WIDTH  line from memory.
- line_valid_in  in  1  line_in valid.
- line_ready_out  out  1  unpacker can accept a line.
- words_out  out  WORD_WIDTH*FMA_COUNT  current beat; lane 0 in the MSBs, matching {fma_out_1, fma_out_2} packing.
- words_valid_out  out  1  words_out valid.
- words_ready_in  in  1  consumer accepts the beat.
- last_out  out  1  current beat is the final beat of its line.
- idle_out  out  1  FIFO empty and no beat pending.
- lines_done_out  out  16  only when UNPACK_STATS_EN is defined.

Behaviour:
- **Reset:** rst_in high asynchronously clears FIFO count, read/write pointers, beat counter and stats counter.
  - Outputs immediately: line_ready_out=1, words_valid_out=0, words_out=0, last_out=0, idle_out=1.
  - Reset mid-line discards all stored and partially emitted lines; no beat is resumed after reset.
- **Input handshake:** a line is accepted on a rising edge with line_valid_in && line_ready_out.
  - line_ready_out = (count != 2), from registered count only; no combinational path from words_ready_in.
  - line_valid_in while line_ready_out=0 is ignored; upstream holds line_in.
- **Latency:** a line accepted at edge N into an empty unpacker gives words_valid_out=1 after edge N, i.e. first beat visible in cycle N+1.
- **Beat order:**
  - Beat k (k=0..BEATS-1) = line[LINE_WIDTH-1-k*W*F -: W*F], with W=WORD_WIDTH and F=FMA_COUNT. The first beat is the MSB slice, the inverse of the write buffer's fill order.
  - words_out = slice of the head entry selected by beat counter when count != 0; 0 otherwise.
- **Output handshake:**
  - words_valid_out = (count != 0).
  - A beat retires on an edge with words_valid_out && words_ready_in.
  - Non-final beat: beat counter +1.
  - Final beat (beat == BEATS-1): beat counter -> 0, head popped, read pointer toggles.
  - words_out and last_out are stable while words_valid_out=1 and words_ready_in=0.
- last_out = words_valid_out && (beat == BEATS-1).
- **FIFO count:**
  - Push only: +1. Pop only: -1.
  - Simultaneous push and pop (count==1, final beat retiring, line accepted): count stays 1; new line becomes head; beat restarts at 0 with no bubble.
  - Count 2 with final beat retiring: line_ready_out still 0 that cycle; rises the cycle after.
- **Throughput:** one beat per cycle sustained when words_ready_in stays high and lines arrive at least every BEATS cycles.
- idle_out = (count == 0).
- Pointer wrap: 1-bit read/write pointers over 2 entries, wrap naturally.

Optional Feature:
- Macro UNPACK_STATS_EN.
- **Defined:** adds output lines_done_out [15:0].
  - Increments on every final-beat retire, wraps 0xFFFF->0x0000.
  - Reset value 0.
- **Undefined:** port and counter absent; all other behaviour identical.

Test Plan:
- **Single line:** reset, push 0x0001_0002_0003_0004_0005_0006 with words_ready_in=1.
  - Beats 0x00010002, 0x00030004, 0x00050006 on consecutive cycles starting the cycle after accept.
  - last_out only on the third beat; idle_out=1 after.
- **Backpressure and full:** push lines A, B, C back-to-back with words_ready_in=0.
  - A and B accepted; line_ready_out=0 from the cycle after B; C held.
  - words_out frozen on A beat 0.
  - Release ready: A's 3 beats, then B's with no bubble; C accepted the cycle after A's final beat.
- **Simultaneous push/pop:** one line stored, final beat retiring on the same edge a new line is accepted.
  - count stays 1; next cycle shows new line beat 0.
  - Beats 0x1111_2222, 0x3333_4444, 0x5555_6666 of a line 0x1111_2222_3333_4444_5555_6666 follow unbroken.
- **Reset mid-line:** assert rst_in asynchronously (mid-cycle) after beat 1 of a line.
  - words_valid_out=0 and words_out=0 immediately; line_ready_out=1.
  - After release, the next pushed line starts at beat 0.
- **Stats (UNPACK_STATS_EN):** stream 65537 lines.
  - lines_done_out reads 0x0001 after the last final beat (wrapped).
  - Reads 0 throughout reset.
- **Parameter sweep:** FMA_COUNT=1, LINE_WIDTH=48.
  - BEATS=3; line 0xAAAA_BBBB_CCCC yields 0xAAAA, 0xBBBB, 0xCCCC.
